divisore_sequenziale: RTL



---
 rtl/divisore_pkg.sv | 13 +
 rtl/passo_divisione.sv | 22 ++
 rtl/divisore_sequenziale.sv | 114 +++++++++++
 3 files changed

// File: rtl/divisore_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Holds the controller state encoding and the default operand width.
package divisore_pkg;

    localparam int DIV_N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stato_t;

endpackage

// File: rtl/passo_divisione.sv
// One restoring shift-subtract step: shift {r,q} left, subtract d if it fits.
// Combinational, zero latency; no flow control.
module passo_divisione #(
    parameter int N = 4
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N:0] r_sh;
    logic       ge;

    // A set r[N] means the shifted value is at least 2^(N+1), so d always fits.
    assign r_sh   = {r[N-1:0], q[N-1]};
    assign ge     = r[N] | (r_sh >= {1'b0, d});
    assign r_next = ge ? (r_sh - {1'b0, d}) : r_sh;
    assign q_next = {q[N-2:0], ge};

endmodule

// File: rtl/divisore_sequenziale.sv
// Sequential unsigned divider, one quotient bit per clock; done N edges after start (same edge for d=0).
// start is accepted only in IDLE; requests while busy are dropped, not queued.
module divisore_sequenziale
    import divisore_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisore,
    output logic [N-1:0] quoziente,
    output logic [N-1:0] resto,
    output logic         done,
    output logic         busy,
    output logic         div0
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    stato_t         stato, stato_next;
    logic [N:0]     r_reg;
    logic [N-1:0]   q_reg;
    logic [N-1:0]   d_reg;
    logic [CW-1:0]  cnt;
    logic [N:0]     r_step;
    logic [N-1:0]   q_step;

    passo_divisione #(.N(N)) u_passo (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stato <= IDLE;
        end else begin
            stato <= stato_next;
        end
    end

    always_comb begin
        stato_next = stato;
        case (stato)
            IDLE: begin
                if (start) begin
                    stato_next = (divisore == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    stato_next = DONE;
                end
            end
            DONE:    stato_next = IDLE;
            default: stato_next = IDLE;
        endcase
    end

    // Both decode the state register directly, so neither depends on inputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        busy = (stato != IDLE);
        done = (stato == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quoziente <= '0;
            resto     <= '0;
            div0      <= 1'b0;
        end else begin
            case (stato)
                IDLE: begin
                    if (start) begin
                        if (divisore != '0) begin
                            q_reg <= dividendo;
                            r_reg <= '0;
                            d_reg <= divisore;
                            cnt   <= CW'(N - 1);
                        end else begin
                            quoziente <= '1;
                            resto     <= dividendo;
                            div0      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                    // Visible results only move on the last iteration.
                    if (cnt == '0) begin
                        quoziente <= q_step;
                        resto     <= r_step[N-1:0];
                        div0      <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
